// File: rtl/up_frame_packer.sv
// up_frame_packer: buffers upstream 64-bit words and emits framed uplink bursts
// (header, payload, XOR checksum tail) on a ready/valid port, counting overflow drops.
module up_frame_packer #(
   parameter int DEPTH       = 32,
   parameter int FRAME_WORDS = 8,
   parameter int TIMEOUT     = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        data_valid,
   input  logic [63:0] up_data,
   input  logic        tx_ready,
   output logic        tx_valid,
   output logic [63:0] tx_data,
   output logic        tx_sop,
   output logic        tx_eop,
   output logic [15:0] ovf_cnt,
   output logic [15:0] frame_seq
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] FW_C = CW'(FRAME_WORDS);
   localparam logic [TW-1:0] TO_C = TW'(TIMEOUT);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HEAD = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;
   localparam logic [1:0] S_TAIL = 2'd3;

   logic [63:0]   r_mem [DEPTH];
   logic [CW-1:0] r_wr_ptr;
   logic [CW-1:0] r_rd_ptr;
   logic [TW-1:0] r_timer;
   logic [1:0]    r_state;
   logic [7:0]    r_left;
   logic [63:0]   r_csum;
   logic          r_tx_valid;
   logic [63:0]   r_tx_data;
   logic          r_tx_sop;
   logic          r_tx_eop;
   logic [15:0]   r_ovf;
   logic [15:0]   r_seq;

   logic [CW-1:0] w_count;
   logic [CW-1:0] w_rd_nxt;
   logic          w_full;
   logic          w_wr;
   logic          w_hs;
   logic          w_go;
   logic [7:0]    w_len;
   logic [63:0]   w_csum;

   assign w_count  = r_wr_ptr - r_rd_ptr;
   assign w_rd_nxt = r_rd_ptr + 1'b1;
   assign w_full   = w_count == CW'(DEPTH);
   assign w_wr     = data_valid && !w_full;
   assign w_hs     = r_tx_valid && tx_ready;
   assign w_go     = (w_count >= FW_C) || (w_count != '0 && r_timer == TO_C);
   assign w_len    = (w_count >= FW_C) ? 8'(FRAME_WORDS) : 8'(w_count);
   assign w_csum   = r_csum ^ r_tx_data;

   always_ff @(posedge clk)
      if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= up_data;

   // Payload words stay in the buffer until their handshake; r_rd_ptr marks the word on tx_data.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_timer    <= '0;
         r_state    <= S_IDLE;
         r_left     <= '0;
         r_csum     <= '0;
         r_tx_valid <= 1'b0;
         r_tx_data  <= '0;
         r_tx_sop   <= 1'b0;
         r_tx_eop   <= 1'b0;
         r_ovf      <= '0;
         r_seq      <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (data_valid && w_full && r_ovf != 16'hFFFF) r_ovf <= r_ovf + 1'b1;
         case (r_state)
            S_IDLE: begin
               r_timer <= (w_count != '0) ? r_timer + 1'b1 : '0;
               if (w_go) begin
                  r_timer    <= '0;
                  r_state    <= S_HEAD;
                  r_left     <= w_len;
                  r_csum     <= '0;
                  r_tx_valid <= 1'b1;
                  r_tx_sop   <= 1'b1;
                  r_tx_data  <= {16'hA55A, r_seq, 8'h00, w_len, 16'h0000};
               end
            end
            S_HEAD:
               if (w_hs) begin
                  r_state   <= S_DATA;
                  r_tx_sop  <= 1'b0;
                  r_tx_data <= r_mem[r_rd_ptr[AW-1:0]];
               end
            S_DATA:
               if (w_hs) begin
                  r_rd_ptr  <= w_rd_nxt;
                  r_csum    <= w_csum;
                  r_left    <= r_left - 1'b1;
                  r_state   <= (r_left == 8'd1) ? S_TAIL : S_DATA;
                  r_tx_eop  <= r_left == 8'd1;
                  r_tx_data <= (r_left == 8'd1) ? w_csum : r_mem[w_rd_nxt[AW-1:0]];
               end
            S_TAIL:
               if (w_hs) begin
                  r_state    <= S_IDLE;
                  r_tx_valid <= 1'b0;
                  r_tx_eop   <= 1'b0;
                  r_seq      <= r_seq + 1'b1;
               end
         endcase
      end

   assign tx_valid  = r_tx_valid;
   assign tx_data   = r_tx_data;
   assign tx_sop    = r_tx_sop;
   assign tx_eop    = r_tx_eop;
   assign ovf_cnt   = r_ovf;
   assign frame_seq = r_seq;
endmodule

// File: tb/tb_up_frame_packer.sv
// tb_up_frame_packer: directed vector table plus hand-written multi-cycle sequences.
module tb_up_frame_packer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        data_valid = 1'b0;
   logic [63:0] up_data = '0;
   logic        tx_ready = 1'b0;
   logic        tx_valid;
   logic [63:0] tx_data;
   logic        tx_sop;
   logic        tx_eop;
   logic [15:0] ovf_cnt;
   logic [15:0] frame_seq;

   int n_tests = 0;
   int n_fail  = 0;
   logic [63:0] exp_q[$];

   typedef struct {
      logic        dv;
      logic [63:0] d;
      logic        rdy;
      logic        ev;
      logic [63:0] ed;
      logic        es;
      logic        ee;
   } vec_t;
   vec_t tbl[$];

   up_frame_packer #(.DEPTH(32), .FRAME_WORDS(8), .TIMEOUT(64)) dut (
      .clk(clk), .rst_n(rst_n), .data_valid(data_valid), .up_data(up_data),
      .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_sop(tx_sop),
      .tx_eop(tx_eop), .ovf_cnt(ovf_cnt), .frame_seq(frame_seq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input logic dv, input logic [63:0] d, input logic rdy,
                      input logic ev, input logic [63:0] ed, input logic es, input logic ee);
      vec_t v;
      v.dv = dv; v.d = d; v.rdy = rdy; v.ev = ev; v.ed = ed; v.es = es; v.ee = ee;
      tbl.push_back(v);
   endtask

   task automatic wr(input logic [63:0] d);
      data_valid = 1'b1;
      up_data    = d;
      @(posedge clk); #1;
      data_valid = 1'b0;
   endtask

   task automatic get_word(input string nm, input logic [63:0] d, input logic s, input logic e);
      int n = 0;
      while (!tx_valid && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "_vld"}, 64'(tx_valid), 64'd1);
      chk(nm, tx_data, d);
      chk({nm, "_sop_eop"}, 64'({tx_sop, tx_eop}), 64'({s, e}));
      @(posedge clk); #1;
   endtask

   task automatic get_frame(input logic [15:0] seq, input int n);
      logic [63:0] x;
      logic [63:0] w;
      x = '0;
      get_word("hdr", {16'hA55A, seq, 8'h00, 8'(n), 16'h0000}, 1'b1, 1'b0);
      for (int i = 0; i < n; i++) begin
         w = exp_q.pop_front();
         x ^= w;
         get_word("pay", w, 1'b0, 1'b0);
      end
      get_word("tail", x, 1'b0, 1'b1);
   endtask

   initial begin
      int n;
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < 8; i++) add(1'b1, 64'(i + 1), 1'b1, 1'b0, '0, 1'b0, 1'b0);
         add(1'b0, '0, 1'b1, 1'b1, {16'hA55A, 16'(b), 32'h0008_0000}, 1'b1, 1'b0);
         for (int i = 0; i < 8; i++) add(1'b0, '0, 1'b1, 1'b1, 64'(i + 1), 1'b0, 1'b0);
         add(1'b0, '0, 1'b1, 1'b1, 64'h8, 1'b0, 1'b1);
         add(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      end

      repeat (3) @(posedge clk);
      #1;
      chk("rst_vld", 64'(tx_valid), 64'd0);
      chk("rst_data", tx_data, 64'd0);
      chk("rst_sop_eop", 64'({tx_sop, tx_eop}), 64'd0);
      chk("rst_ovf", 64'(ovf_cnt), 64'd0);
      chk("rst_seq", 64'(frame_seq), 64'd0);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         data_valid = tbl[i].dv;
         up_data    = tbl[i].d;
         tx_ready   = tbl[i].rdy;
         @(posedge clk); #1;
         chk($sformatf("vec%0d_vld", i), 64'(tx_valid), 64'(tbl[i].ev));
         if (tbl[i].ev) begin
            chk($sformatf("vec%0d_data", i), tx_data, tbl[i].ed);
            chk($sformatf("vec%0d_sop_eop", i), 64'({tx_sop, tx_eop}), 64'({tbl[i].es, tbl[i].ee}));
         end
      end
      data_valid = 1'b0;
      chk("seq_after_tbl", 64'(frame_seq), 64'd2);

      // Short frame flushed by idle timeout; latency counted from the first word's edge.
      tx_ready = 1'b1;
      wr(64'hA); wr(64'hB); wr(64'hC);
      exp_q = '{64'hA, 64'hB, 64'hC};
      n = 2;
      while (!tx_valid && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("timeout_latency", 64'(n), 64'd65);
      get_frame(16'd2, 3);

      // Back-pressure for 5 cycles while the third payload word is presented.
      for (int i = 0; i < 8; i++) begin
         wr(64'hC0DE_0000_0000_0000 | 64'(i * 37 + 5));
         exp_q.push_back(64'hC0DE_0000_0000_0000 | 64'(i * 37 + 5));
      end
      begin
         logic [63:0] x;
         logic [63:0] w;
         x = '0;
         get_word("bp_hdr", 64'hA55A_0003_0008_0000, 1'b1, 1'b0);
         for (int i = 0; i < 8; i++) begin
            w = exp_q.pop_front();
            x ^= w;
            if (i == 2) begin
               tx_ready = 1'b0;
               repeat (5) begin
                  @(posedge clk); #1;
                  chk("bp_hold_vld", 64'(tx_valid), 64'd1);
                  chk("bp_hold_data", tx_data, w);
                  chk("bp_hold_sop_eop", 64'({tx_sop, tx_eop}), 64'd0);
               end
               tx_ready = 1'b1;
            end
            get_word("bp_pay", w, 1'b0, 1'b0);
         end
         get_word("bp_tail", x, 1'b0, 1'b1);
      end

      // Overflow: 40 writes with the port stalled keeps only the first 32.
      tx_ready = 1'b0;
      for (int i = 0; i < 40; i++) begin
         wr(64'h1000 + 64'(i));
         if (i < 32) exp_q.push_back(64'h1000 + 64'(i));
      end
      chk("ovf_8", 64'(ovf_cnt), 64'd8);
      tx_ready = 1'b1;
      for (int f = 0; f < 4; f++) get_frame(16'(4 + f), 8);
      @(posedge clk); #1;
      chk("ovf_drain_vld", 64'(tx_valid), 64'd0);
      chk("ovf_drain_seq", 64'(frame_seq), 64'd8);

      // Asynchronous reset while the fourth payload word is presented.
      for (int i = 0; i < 8; i++) wr(64'h300 + 64'(i));
      get_word("rf_hdr", 64'hA55A_0008_0008_0000, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) get_word("rf_pay", 64'h300 + 64'(i), 1'b0, 1'b0);
      chk("rf_pre_data", tx_data, 64'h303);
      rst_n = 1'b0;
      #1;
      chk("rf_vld", 64'(tx_valid), 64'd0);
      chk("rf_data", tx_data, 64'd0);
      chk("rf_sop_eop", 64'({tx_sop, tx_eop}), 64'd0);
      chk("rf_ovf", 64'(ovf_cnt), 64'd0);
      chk("rf_seq", 64'(frame_seq), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      exp_q.delete();
      for (int i = 0; i < 8; i++) begin
         wr(64'h400 + 64'(i));
         exp_q.push_back(64'h400 + 64'(i));
      end
      get_frame(16'd0, 8);
      chk("rf_seq_next", 64'(frame_seq), 64'd1);

      // Saturation of the drop counter.
      tx_ready   = 1'b0;
      data_valid = 1'b1;
      repeat (32 + 65534) @(posedge clk);
      #1;
      chk("ovf_fffe", 64'(ovf_cnt), 64'hFFFE);
      repeat (6) @(posedge clk);
      #1;
      chk("ovf_sat", 64'(ovf_cnt), 64'hFFFF);
      data_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
